pipe_elastic_buffer: RTL and testbench
======================================

// Module: pipe_elastic_buffer
// PURPOSE
//  Parametrised elastic FIFO buffer that sits between two pipeline stages
//  (e.g. IF->ID, ID->EX). It carries a packed stage payload such as
//  fetch_data_t or decode_data_t, and replaces the bare stall/flush pipeline
//  register with a valid/ready handshake.
//  It decouples producer and consumer by DEPTH entries, supports a pipeline
//  flush on branch or exception, and optionally passes the consumer's ready
//  straight through when the buffer is full.
// PARAMETERS
//  DATA_W      64  payload width in bits; set to $bits(<stage struct>)
//  DEPTH       2   number of entries, >=1; does not need to be a power of 2
//  PASS_READY  0   1: in_ready may be asserted when full if out_ready=1
//                  (combinational path from out_ready to in_ready)
//  CNT_W       $clog2(DEPTH+1)  width of count (derived, do not override)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  reset      in   1       asynchronous, active-low reset
//  in_valid   in   1       producer offers in_data this cycle
//  in_ready   out  1       buffer accepts in_data this cycle
//  in_data    in   DATA_W  payload from producer stage
//  out_valid  out  1       out_data holds the oldest valid entry
//  out_ready  in   1       consumer takes out_data this cycle
//  out_data   out  DATA_W  oldest entry (head of queue)
//  flush      in   1       discard all entries (from branch_data_t.flush)
//  count      out  CNT_W   number of valid entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0; all
//    storage entries cleared to 0. Resulting outputs: out_valid=0,
//    out_data=0, in_ready=1.
//  - Transfers: push = in_valid & in_ready; pop = out_valid & out_ready.
//    Both are evaluated on the same rising edge.
//  - out_valid = (count!=0); out_data = mem[rd_ptr], driven combinationally
//    from storage.
//    When count=0, out_data is the stale entry value; consumers must ignore it.
//  - in_ready = (count<DEPTH) | (PASS_READY & out_ready). in_ready does not
//    depend on in_valid.
//  - Latency: an entry pushed at edge N is visible on out_data/out_valid
//    after edge N. There is no same-cycle bypass.
//  - Pointer arithmetic: pointers are $clog2(DEPTH) bits (1 bit if DEPTH=1).
//    Increment wraps explicitly: ptr==DEPTH-1 -> 0. No modulo-2^n wrap.
//  - count update: push only -> +1; pop only -> -1; both -> unchanged;
//    neither -> unchanged.
//  - Full with PASS_READY=1: push and pop in the same cycle are legal.
//    The new entry overwrites the slot being freed, count stays DEPTH,
//    and FIFO order is preserved.
//  - Empty with push and out_ready=1: only the push happens, because
//    out_valid=0 means no pop.
//  - flush=1 has priority over everything: on the edge, rd_ptr=wr_ptr=0
//    and count=0. Any push or pop offered that cycle is dropped (no state
//    change beyond the clear).
//    Handshake outputs are not gated by flush: the producer may still see
//    in_ready=1, and the item is lost by design.
//  - Storage contents are not cleared on flush, only on reset.
//  - Overflow and underflow cannot occur by construction: push is blocked
//    when full and PASS_READY=0, and pop is blocked when empty.
//  - Reset asserted mid-operation clears all state immediately, regardless
//    of clk.
//  - Assertions (sim only): count<=DEPTH; out_valid==(count!=0); in_data
//    has no X when push=1.
// TESTING
//  - Reset: hold reset=0 for 3 cycles with random inputs -> count=0,
//    out_valid=0, in_ready=1, out_data=0.
//  - Fill (DEPTH=2, PASS_READY=0, out_ready=0): push 0xA then 0xB.
//    -> count=2, in_ready=0. Offering 0xC is ignored and count stays 2.
//    Then out_ready=1 -> out_data 0xA, then 0xB, then out_valid=0.
//  - Steady stream (DEPTH=3): push 1..7 back-to-back with out_ready
//    toggling 1,0,1,... -> out sequence exactly 1..7, pointers wrap
//    through 2->0, count never exceeds 3.
//  - Simultaneous push/pop at count=1 (head 0x11, push 0x22,
//    out_ready=1) -> count stays 1, next out_data=0x22.
//  - Flush (count=2, in_valid=1 data 0x33, flush=1) -> next cycle count=0,
//    out_valid=0, 0x33 is never output. The next push 0x44 appears as
//    the head.
//  - PASS_READY=1, DEPTH=2, full, out_ready=1, in_valid=1 (0x55) ->
//    in_ready=1, head pops, count stays 2, 0x55 is output after the
//    remaining entry.
//    Also: reset=0 asserted mid-stream -> count=0 immediately, without
//    waiting for a clock edge.

Source files
------------

// File: rtl/pipe_elastic_buffer.sv
// Elastic FIFO between two pipeline stages: DEPTH entries of DATA_W-bit payload, with a valid/ready handshake on each side.
// Latency: an entry pushed on edge N is presented on out_data/out_valid after edge N. There is no same-cycle bypass.
// Backpressure: in_ready drops when full. With PASS_READY=1 it stays high while out_ready=1 (a combinational path).
//
// Ports:
//   clk                    rising-edge clock
//   reset                  asynchronous, active-low; clears pointers, count and storage
//   in_valid/in_ready/in_data     producer side handshake and payload
//   out_valid/out_ready/out_data  consumer side; out_data is the head entry, read combinationally
//   flush                  drops every entry on the next edge; this takes priority over push and pop
//   count                  number of valid entries, 0..DEPTH
module pipe_elastic_buffer #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 2,
    parameter bit PASS_READY = 1'b0,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              push;
    logic              pop;

    // DEPTH need not be a power of two, so the pointer wraps explicitly at DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (count != '0);
    assign in_ready  = (count < CNT_FULL) | (PASS_READY & out_ready);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // When the buffer is full and a push and a pop happen together, wr_ptr equals rd_ptr.
    // The new entry then lands in the slot being freed, and rd_ptr moves on to the next-oldest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; only the bookkeeping is cleared.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset) begin
            assert (count <= CNT_FULL)
                else $error("pipe_elastic_buffer: count %0d exceeds DEPTH", count);
            assert (out_valid == (count != '0))
                else $error("pipe_elastic_buffer: out_valid inconsistent with count");
            if (push) begin
                assert (!$isunknown(in_data))
                    else $error("pipe_elastic_buffer: X on in_data during push");
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_elastic_buffer.sv
// Three buffer instances are checked against a queue-based reference: lane0 is D=2/PR=0, lane1 is D=3/PR=0, lane2 is D=2/PR=1.
// Inputs are driven 1 time unit after posedge. Each lane's monitor samples at negedge and compares against its queue.
// Directed sequences and randomized traffic are mixed, with flushes and a reset asserted mid-stream.
module tb_pipe_elastic_buffer;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         iv   [3];
    logic         ir   [3];
    logic [W-1:0] id   [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [W-1:0] od   [3];
    logic         fl   [3];
    logic [1:0]   cnt  [3];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lane%0d actual=%0h expected=%0h t=%0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic set_lane(input int g, input logic v, input logic [W-1:0] d, input logic r, input logic f);
        iv[g]   = v;
        id[g]   = d;
        ordy[g] = r;
        fl[g]   = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int g = 0; g < 3; g++) set_lane(g, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic flush_lane(input int g);
        set_lane(g, 1'b0, '0, 1'b0, 1'b1);
        tick();
        set_lane(g, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic randomize_inputs(input int v_bias, input int r_bias);
        for (int g = 0; g < 3; g++) begin
            iv[g]   = ($urandom_range(0, 9) < v_bias);
            id[g]   = W'($urandom);
            ordy[g] = ($urandom_range(0, 9) < r_bias);
            fl[g]   = ($urandom_range(0, 29) == 0);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int D = (g == 1) ? 3 : 2;
        localparam bit P = (g == 2);

        pipe_elastic_buffer #(
            .DATA_W(W),
            .DEPTH(D),
            .PASS_READY(P)
        ) dut (
            .clk(clk),
            .reset(rst_n),
            .in_valid(iv[g]),
            .in_ready(ir[g]),
            .in_data(id[g]),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .out_data(od[g]),
            .flush(fl[g]),
            .count(cnt[g])
        );

        // Reference: a plain queue holds the entries in order.
        // Accepting an entry is a push_back; consuming one is a pop_front.
        logic [W-1:0] q [$];
        logic         exp_rdy;

        initial begin
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    q.delete();
                end else begin
                    exp_rdy = (q.size() < D) || (P && ordy[g]);
                    chk("in_ready", g, 32'(ir[g]), 32'(exp_rdy));
                    chk("out_valid", g, 32'(ov[g]), 32'(q.size() != 0));
                    chk("count", g, 32'(cnt[g]), 32'(q.size()));
                    if (q.size() != 0) chk("out_data", g, 32'(od[g]), 32'(q[0]));
                    if (fl[g]) begin
                        q.delete();
                    end else begin
                        if (q.size() != 0 && ordy[g]) void'(q.pop_front());
                        if (iv[g] && exp_rdy) q.push_back(id[g]);
                    end
                end
            end
        end
    end

    logic [W-1:0] got [$];
    int           k;
    int           guard;
    logic         acc;

    initial begin
        rst_n = 1'b0;
        randomize_inputs(5, 5);

        // Reset held for 3 cycles while the inputs take random values.
        repeat (3) begin
            @(posedge clk);
            #1;
            randomize_inputs(5, 5);
        end
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_count", g, 32'(cnt[g]), 0);
            chk("rst_out_valid", g, 32'(ov[g]), 0);
            chk("rst_in_ready", g, 32'(ir[g]), 1);
            chk("rst_out_data", g, 32'(od[g]), 0);
        end
        @(posedge clk);
        #1;
        idle_all();
        rst_n = 1'b1;
        tick();

        // Fill test on lane0: the third push is refused, then the entries drain in order.
        set_lane(0, 1'b1, 16'h000A, 1'b0, 1'b0); tick();
        set_lane(0, 1'b1, 16'h000B, 1'b0, 1'b0); tick();
        set_lane(0, 1'b1, 16'h000C, 1'b0, 1'b0);
        @(negedge clk);
        chk("fill_count", 0, 32'(cnt[0]), 2);
        chk("fill_in_ready", 0, 32'(ir[0]), 0);
        tick();
        @(negedge clk);
        chk("fill_c_ignored", 0, 32'(cnt[0]), 2);
        tick();
        set_lane(0, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk); chk("drain_a", 0, 32'(od[0]), 32'h000A);
        tick();
        @(negedge clk); chk("drain_b", 0, 32'(od[0]), 32'h000B);
        tick();
        @(negedge clk); chk("drain_empty", 0, 32'(ov[0]), 0);
        tick();

        // Steady stream on lane1: out_ready toggles every cycle and the pointers wrap.
        flush_lane(1);
        k = 1;
        guard = 0;
        while (k <= 7 && guard < 60) begin
            set_lane(1, 1'b1, W'(k), (guard % 2 == 0), 1'b0);
            @(negedge clk);
            acc = ir[1];
            if (ov[1] && ordy[1]) got.push_back(od[1]);
            tick();
            if (acc) k++;
            guard++;
        end
        chk("stream_pushed", 1, 32'(k), 8);
        set_lane(1, 1'b0, '0, 1'b1, 1'b0);
        guard = 0;
        while (got.size() < 7 && guard < 20) begin
            @(negedge clk);
            if (ov[1] && ordy[1]) got.push_back(od[1]);
            tick();
            guard++;
        end
        chk("stream_len", 1, 32'(got.size()), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < got.size()) chk("stream_order", 1, 32'(got[i]), 32'(i + 1));
        end

        // Simultaneous push and pop at count=1.
        flush_lane(0);
        set_lane(0, 1'b1, 16'h0011, 1'b0, 1'b0); tick();
        set_lane(0, 1'b1, 16'h0022, 1'b1, 1'b0); tick();
        set_lane(0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("simul_count", 0, 32'(cnt[0]), 1);
        chk("simul_head", 0, 32'(od[0]), 32'h0022);
        tick();

        // Flush while an entry is offered: the offered 0x33 is dropped.
        flush_lane(0);
        set_lane(0, 1'b1, 16'h0001, 1'b0, 1'b0); tick();
        set_lane(0, 1'b1, 16'h0002, 1'b0, 1'b0); tick();
        set_lane(0, 1'b1, 16'h0033, 1'b0, 1'b1);
        @(negedge clk); chk("pre_flush_count", 0, 32'(cnt[0]), 2);
        tick();
        @(negedge clk);
        chk("flush_count", 0, 32'(cnt[0]), 0);
        chk("flush_out_valid", 0, 32'(ov[0]), 0);
        tick();
        set_lane(0, 1'b1, 16'h0044, 1'b0, 1'b0); tick();
        set_lane(0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_flush_head", 0, 32'(od[0]), 32'h0044);
        chk("post_flush_count", 0, 32'(cnt[0]), 1);
        tick();
        flush_lane(0);

        // Lane2 (PASS_READY=1): a push is accepted while full because out_ready=1.
        flush_lane(2);
        set_lane(2, 1'b1, 16'h0001, 1'b0, 1'b0); tick();
        set_lane(2, 1'b1, 16'h0002, 1'b0, 1'b0); tick();
        set_lane(2, 1'b1, 16'h0055, 1'b1, 1'b0);
        @(negedge clk);
        chk("pr_full_in_ready", 2, 32'(ir[2]), 1);
        chk("pr_full_count", 2, 32'(cnt[2]), 2);
        tick();
        set_lane(2, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pr_count_after", 2, 32'(cnt[2]), 2);
        chk("pr_head_after", 2, 32'(od[2]), 32'h0002);
        tick();
        set_lane(2, 1'b0, '0, 1'b1, 1'b0); tick();
        @(negedge clk); chk("pr_then_55", 2, 32'(od[2]), 32'h0055);
        tick();
        idle_all();
        tick();

        // Randomized traffic: a producer-heavy phase, then a consumer-heavy phase.
        for (int c = 0; c < 300; c++) begin
            randomize_inputs(8, 4);
            tick();
        end
        for (int c = 0; c < 300; c++) begin
            randomize_inputs(3, 8);
            tick();
        end

        // Reset asserted mid-stream, away from any clock edge.
        for (int c = 0; c < 20; c++) begin
            randomize_inputs(8, 2);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("async_rst_count", g, 32'(cnt[g]), 0);
            chk("async_rst_out_valid", g, 32'(ov[g]), 0);
            chk("async_rst_out_data", g, 32'(od[g]), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 200; c++) begin
            randomize_inputs(6, 6);
            tick();
        end

        idle_all();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
